// File: rtl/axis_frame_gen_chk.sv
// axis_frame_gen_chk
//   Generates runs of AXI-Stream frames with an incrementing byte pattern and
//   independently checks a returned stream against the same pattern.
//   Byte k of frame n carries (n + k) mod 256, in little-endian lane order.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_start                 single-cycle pulse that begins a run (ignored while busy)
//   i_frame_len             frame length in bytes (0 behaves as 1), sampled on start
//   i_frame_cnt             frames per run, sampled on start
//   m_axis_*                generated stream (tdata/tkeep/tvalid/tlast, tready in)
//   s_axis_*                returned stream under check (tready out)
//   o_busy                  generator is sending or in the inter-frame gap
//   o_done                  run complete, sticky until next start or reset
//   o_err                   at least one bad frame seen, sticky
//   o_good_cnt, o_bad_cnt   saturating counts of checked frames
module axis_frame_gen_chk #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IFG_CYCLES = 12
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic [15:0]             i_frame_len,
   input  logic [15:0]             i_frame_cnt,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_err,
   output logic [15:0]             o_good_cnt,
   output logic [15:0]             o_bad_cnt
);

   localparam int unsigned BYTES  = DATA_WIDTH / 8;
   localparam int unsigned BEAT_W = DATA_WIDTH + BYTES + 1;
   localparam logic [7:0]  GAP_LOAD = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t      state;
   logic [16:0] len_q;      // effective frame length (never 0)
   logic [15:0] cnt_q;
   logic [15:0] gen_n;      // generator frame index
   logic [16:0] gen_off;    // byte offset of the beat currently presented
   logic [7:0]  gap_cnt;
   logic        start_acc;
   logic [16:0] eff_len;

   logic [15:0] chk_n;
   logic [16:0] chk_cnt;
   logic        chk_bad;
   logic [16:0] beat_bytes;
   logic        beat_bad;
   logic [16:0] frame_bytes;
   logic        frame_bad;

   // Builds {tlast, tkeep, tdata} for the beat starting at byte offset off.
   function automatic logic [BEAT_W-1:0] make_beat(input logic [7:0]  n,
                                                   input logic [16:0] off,
                                                   input logic [16:0] len);
      logic [DATA_WIDTH-1:0] d;
      logic [BYTES-1:0]      kp;
      logic                  lst;
      d  = '0;
      kp = '0;
      for (int unsigned i = 0; i < BYTES; i++) begin
         if (off + 17'(i) < len) begin
            d[i*8 +: 8] = n + off[7:0] + 8'(i);
            kp[i]       = 1'b1;
         end
      end
      lst = (off + 17'(BYTES) >= len);
      return {lst, kp, d};
   endfunction

   assign start_acc     = i_start && !o_busy;
   assign eff_len       = (i_frame_len == 16'd0) ? 17'd1 : {1'b0, i_frame_len};
   assign o_busy        = (state == SEND) || (state == GAP);
   assign s_axis_tready = !i_reset;

   // Generator
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= IDLE;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         o_done        <= 1'b0;
         len_q         <= '0;
         cnt_q         <= '0;
         gen_n         <= '0;
         gen_off       <= '0;
         gap_cnt       <= '0;
      end else if (start_acc) begin
         len_q   <= eff_len;
         cnt_q   <= i_frame_cnt;
         gen_n   <= '0;
         gen_off <= '0;
         o_done  <= 1'b0;
         if (i_frame_cnt != 16'd0) begin
            state         <= SEND;
            m_axis_tvalid <= 1'b1;
            {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= make_beat(8'd0, 17'd0, eff_len);
         end else begin
            state <= DONE;
         end
      end else begin
         case (state)
            SEND: begin
               if (m_axis_tready) begin
                  if (m_axis_tlast) begin
                     gen_n   <= gen_n + 16'd1;
                     gen_off <= '0;
                     // With no gap and frames remaining, the next frame's first
                     // beat goes out back-to-back without leaving SEND.
                     if (IFG_CYCLES == 0 && (gen_n + 16'd1 != cnt_q)) begin
                        {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <=
                           make_beat(gen_n[7:0] + 8'd1, 17'd0, len_q);
                     end else begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tdata  <= '0;
                        m_axis_tkeep  <= '0;
                        gap_cnt       <= GAP_LOAD;
                        state         <= (IFG_CYCLES == 0) ? DONE : GAP;
                     end
                  end else begin
                     gen_off <= gen_off + 17'(BYTES);
                     {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <=
                        make_beat(gen_n[7:0], gen_off + 17'(BYTES), len_q);
                  end
               end
            end
            GAP: begin
               if (gap_cnt == 8'd0) begin
                  if (gen_n == cnt_q) begin
                     state <= DONE;
                  end else begin
                     state         <= SEND;
                     m_axis_tvalid <= 1'b1;
                     {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <=
                        make_beat(gen_n[7:0], 17'd0, len_q);
                  end
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            DONE: begin
               o_done <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Checker: per-beat evaluation against its own frame/byte indices
   always_comb begin
      beat_bytes = '0;
      beat_bad   = 1'b0;
      for (int unsigned i = 0; i < BYTES; i++) begin
         if (s_axis_tkeep[i]) begin
            beat_bytes = beat_bytes + 17'd1;
            if (s_axis_tdata[i*8 +: 8] != chk_n[7:0] + chk_cnt[7:0] + 8'(i))
               beat_bad = 1'b1;
         end
      end
      if (!s_axis_tlast && (s_axis_tkeep != '1))
         beat_bad = 1'b1;
      frame_bytes = chk_cnt + beat_bytes;
      frame_bad   = chk_bad || beat_bad || (frame_bytes != len_q);
   end

   // A start in the same cycle as a returned tlast wins: that frame is dropped.
   always_ff @(posedge i_clk) begin
      if (i_reset || start_acc) begin
         chk_n      <= '0;
         chk_cnt    <= '0;
         chk_bad    <= 1'b0;
         o_err      <= 1'b0;
         o_good_cnt <= '0;
         o_bad_cnt  <= '0;
      end else if (s_axis_tvalid) begin
         if (s_axis_tlast) begin
            if (frame_bad) begin
               o_err <= 1'b1;
               if (o_bad_cnt != 16'hFFFF) o_bad_cnt <= o_bad_cnt + 16'd1;
            end else begin
               if (o_good_cnt != 16'hFFFF) o_good_cnt <= o_good_cnt + 16'd1;
            end
            chk_n   <= chk_n + 16'd1;
            chk_cnt <= '0;
            chk_bad <= 1'b0;
         end else begin
            chk_cnt <= frame_bytes;
            chk_bad <= chk_bad || beat_bad;
         end
      end
   end

endmodule
